// File: rtl/bt656_framer.sv
// BT.656 525-line framer: wraps a 4:2:2 byte stream in EAV/SAV codes and blanking fill.
// Define BT656_GUARD_EN to clamp active bytes 0x00/0xFF to 0x01/0xFE.
module bt656_framer #(
    parameter int ActiveBytes = 1440,
    parameter int HBlankBytes = 268,
    parameter int TotalLines  = 525
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [7:0]  DIn,
    output logic        InRequest,
    output logic [10:0] Col,
    output logic [9:0]  Line,
    output logic [7:0]  DOut,
    output logic        Field
);

    localparam logic [10:0] BLANK_START  = 11'd4;
    localparam logic [10:0] SAV_START    = 11'(4 + HBlankBytes);
    localparam logic [10:0] ACTIVE_START = 11'(8 + HBlankBytes);
    localparam logic [10:0] LAST_HCOUNT  = 11'(8 + HBlankBytes + ActiveBytes - 1);
    localparam logic [9:0]  LAST_LINE    = 10'(TotalLines);

    typedef enum logic [1:0] {
        REGION_EAV,
        REGION_BLANK,
        REGION_SAV,
        REGION_ACTIVE
    } region_e;

    logic [10:0] hcount_q, hcount_d;
    logic [9:0]  line_q, line_d;
    logic [7:0]  dout_q, dout_d;
    logic        field_q, field_d;

    region_e     region;
    logic [10:0] region_off;
    logic        f_bit, v_bit, h_bit;
    logic [7:0]  xy;
    logic [7:0]  fill;
    logic [7:0]  active_byte;

    // The F/V tables are fixed for 525-line timing.
    function automatic logic field_of(input logic [9:0] ln);
        return !((ln >= 10'd4) && (ln <= 10'd265));
    endfunction

    function automatic logic vblank_of(input logic [9:0] ln);
        return (ln <= 10'd19) || ((ln >= 10'd264) && (ln <= 10'd282));
    endfunction

    always_comb begin : decode
        if (hcount_q < BLANK_START) begin
            region     = REGION_EAV;
            region_off = hcount_q;
        end else if (hcount_q < SAV_START) begin
            region     = REGION_BLANK;
            region_off = hcount_q - BLANK_START;
        end else if (hcount_q < ACTIVE_START) begin
            region     = REGION_SAV;
            region_off = hcount_q - SAV_START;
        end else begin
            region     = REGION_ACTIVE;
            region_off = hcount_q - ACTIVE_START;
        end
        f_bit = field_q;
        v_bit = vblank_of(line_q);
        h_bit = (region == REGION_EAV);
        xy    = {1'b1, f_bit, v_bit, h_bit, v_bit ^ h_bit, f_bit ^ h_bit,
                 f_bit ^ v_bit, f_bit ^ v_bit ^ h_bit};
        fill  = region_off[0] ? 8'h10 : 8'h80;
    end

    always_comb begin : guard
`ifdef BT656_GUARD_EN
        if (DIn == 8'h00) begin
            active_byte = 8'h01;
        end else if (DIn == 8'hFF) begin
            active_byte = 8'hFE;
        end else begin
            active_byte = DIn;
        end
`else
        active_byte = DIn;
`endif
    end

    always_comb begin : request
        InRequest = (region == REGION_ACTIVE) && !v_bit;
        Col       = InRequest ? region_off : '0;
    end

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path can leave a value unassigned and infer a latch.
    always_comb begin : next_state
        dout_d   = fill;
        hcount_d = hcount_q + 11'd1;
        line_d   = line_q;

        unique case (region)
            REGION_EAV, REGION_SAV: begin
                case (region_off[1:0])
                    2'd0:    dout_d = 8'hFF;
                    2'd3:    dout_d = xy;
                    default: dout_d = 8'h00;
                endcase
            end
            REGION_BLANK:  dout_d = fill;
            REGION_ACTIVE: if (!v_bit) dout_d = active_byte;
        endcase

        if (hcount_q == LAST_HCOUNT) begin
            hcount_d = '0;
            line_d   = (line_q == LAST_LINE) ? 10'd1 : line_q + 10'd1;
        end
        // Field follows the line it is about to enter, so the EAV of a new line carries its F.
        field_d = field_of(line_d);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            hcount_q <= '0;
            line_q   <= 10'd1;
            dout_q   <= 8'h80;
            field_q  <= 1'b1;
        end else begin
            hcount_q <= hcount_d;
            line_q   <= line_d;
            dout_q   <= dout_d;
            field_q  <= field_d;
        end
    end

    assign Line  = line_q;
    assign DOut  = dout_q;
    assign Field = field_q;

endmodule

// File: tb/tb_bt656_framer.sv
// Bench for bt656_framer: a full-size instance and a short-line instance share stimulus
// and are compared against a byte-position reference model.
module tb_bt656_framer;

    localparam int FH = 268;
    localparam int FA = 1440;
    localparam int SH = 8;
    localparam int SA = 16;
    localparam int F_LINE = FH + 8 + FA;
    localparam int S_LINE = SH + 8 + SA;
    localparam int S_FRAME = 525 * S_LINE;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    logic [7:0] DIn = 8'h00;

    logic        req_f, req_s;
    logic [10:0] col_f, col_s;
    logic [9:0]  line_f, line_s;
    logic [7:0]  dout_f, dout_s;
    logic        field_f, field_s;

    always #5 Clock = ~Clock;

    bt656_framer dut_f (
        .Clock(Clock), .Reset(Reset), .DIn(DIn), .InRequest(req_f), .Col(col_f),
        .Line(line_f), .DOut(dout_f), .Field(field_f)
    );

    bt656_framer #(.ActiveBytes(SA), .HBlankBytes(SH)) dut_s (
        .Clock(Clock), .Reset(Reset), .DIn(DIn), .InRequest(req_s), .Col(col_s),
        .Line(line_s), .DOut(dout_s), .Field(field_s)
    );

    // Model position (next byte to emit) and expectations for the current cycle.
    int h_f = 0, ln_f = 1, h_s = 0, ln_s = 1;
    int pos_h_f, pos_ln_f, pos_h_s, pos_ln_s;
    logic        ereq_f, ereq_s;
    logic [10:0] ecol_f, ecol_s;
    logic [7:0]  edout_f, edout_s;
    logic [9:0]  eline_f, eline_s;
    logic        efield_f, efield_s;

    int n_checks = 0;
    int n_pass = 0;
    int since_rel = 0;

    function automatic int f_of(int ln);
        return (ln >= 4 && ln <= 265) ? 0 : 1;
    endfunction

    function automatic int v_of(int ln);
        return (ln <= 19 || (ln >= 264 && ln <= 282)) ? 1 : 0;
    endfunction

    function automatic logic [7:0] code_xy(int f, int v, int h);
        int x = 128 + 64 * f + 32 * v + 16 * h + 8 * (v ^ h) + 4 * (f ^ h) + 2 * (f ^ v) + (f ^ v ^ h);
        return 8'(x);
    endfunction

    function automatic logic [7:0] guarded(logic [7:0] d);
`ifdef BT656_GUARD_EN
        if (d == 8'h00) return 8'h01;
        if (d == 8'hFF) return 8'hFE;
`endif
        return d;
    endfunction

    function automatic logic [7:0] ref_byte(int h, int ln, int hb, logic [7:0] din);
        int sav = 4 + hb;
        int act = sav + 4;
        int f = f_of(ln);
        int v = v_of(ln);
        if (h < 4)   return (h == 0) ? 8'hFF : (h == 3) ? code_xy(f, v, 1) : 8'h00;
        if (h < sav) return ((h - 4) % 2 == 0) ? 8'h80 : 8'h10;
        if (h < act) return (h == sav) ? 8'hFF : (h == sav + 3) ? code_xy(f, v, 0) : 8'h00;
        if (v == 1)  return ((h - act) % 2 == 0) ? 8'h80 : 8'h10;
        return guarded(din);
    endfunction

    task automatic drive(input logic rst_v, input logic [7:0] din);
        @(negedge Clock);
        Reset = rst_v;
        DIn = din;
        ereq_f = (h_f >= FH + 8) && (v_of(ln_f) == 0);
        ereq_s = (h_s >= SH + 8) && (v_of(ln_s) == 0);
        ecol_f = ereq_f ? 11'(h_f - (FH + 8)) : 11'd0;
        ecol_s = ereq_s ? 11'(h_s - (SH + 8)) : 11'd0;
        pos_h_f = h_f; pos_ln_f = ln_f;
        pos_h_s = h_s; pos_ln_s = ln_s;
        if (!rst_v) begin
            edout_f = 8'h80; edout_s = 8'h80;
            h_f = 0; ln_f = 1; h_s = 0; ln_s = 1;
        end else begin
            edout_f = ref_byte(h_f, ln_f, FH, din);
            edout_s = ref_byte(h_s, ln_s, SH, din);
            h_f++;
            if (h_f == F_LINE) begin h_f = 0; ln_f = (ln_f == 525) ? 1 : ln_f + 1; end
            h_s++;
            if (h_s == S_LINE) begin h_s = 0; ln_s = (ln_s == 525) ? 1 : ln_s + 1; end
        end
        eline_f = 10'(ln_f); efield_f = (f_of(ln_f) == 1);
        eline_s = 10'(ln_s); efield_s = (f_of(ln_s) == 1);
        #1;
    endtask

    task automatic step_edge();
        @(posedge Clock);
        #1;
        if (Reset) since_rel++;
        else since_rel = 0;
    endtask

    task automatic test_reset();
        drive(1'b0, 8'h12); step_edge();
        drive(1'b0, 8'hFF); step_edge();
        drive(1'b0, 8'($urandom));
        n_checks++; if (req_f !== 1'b0) $display("FAIL reset_inrequest: got %b want 0", req_f); else n_pass++;
        n_checks++; if (col_f !== 11'd0) $display("FAIL reset_col: got %0d want 0", col_f); else n_pass++;
        step_edge();
        n_checks++; if (dout_f !== 8'h80) $display("FAIL reset_dout: got %h want 80", dout_f); else n_pass++;
        n_checks++; if (line_f !== 10'd1) $display("FAIL reset_line: got %0d want 1", line_f); else n_pass++;
        n_checks++; if (field_f !== 1'b1) $display("FAIL reset_field: got %b want 1", field_f); else n_pass++;
        n_checks++; if (dout_s !== 8'h80) $display("FAIL reset_dout_small: got %h want 80", dout_s); else n_pass++;
    endtask

    task automatic test_first_line();
        logic [7:0] eav[4];
        logic [7:0] sav[4];
        logic [7:0] blk[4];
        int errs = 0, first_bad = -1, saw_req = 0;
        for (int i = 0; i < F_LINE; i++) begin
            drive(1'b1, 8'($urandom));
            if (req_f === 1'b1) saw_req = 1;
            if (req_f !== ereq_f || col_f !== ecol_f || req_s !== ereq_s || col_s !== ecol_s) errs++;
            step_edge();
            if (dout_f !== edout_f || line_f !== eline_f || field_f !== efield_f ||
                dout_s !== edout_s || line_s !== eline_s || field_s !== efield_s) errs++;
            if (errs != 0 && first_bad < 0) first_bad = since_rel;
            if (pos_ln_f == 1 && pos_h_f < 4) eav[pos_h_f] = dout_f;
            if (pos_ln_f == 1 && pos_h_f >= 4 && pos_h_f < 8) blk[pos_h_f - 4] = dout_f;
            if (pos_ln_f == 1 && pos_h_f >= FH + 4 && pos_h_f < FH + 8) sav[pos_h_f - FH - 4] = dout_f;
        end
        n_checks++; if ({eav[0], eav[1], eav[2], eav[3]} !== 32'hFF0000F1)
            $display("FAIL line1_eav: got %h%h%h%h want FF0000F1", eav[0], eav[1], eav[2], eav[3]); else n_pass++;
        n_checks++; if ({blk[0], blk[1], blk[2], blk[3]} !== 32'h80108010)
            $display("FAIL line1_blank: got %h%h%h%h want 80108010", blk[0], blk[1], blk[2], blk[3]); else n_pass++;
        n_checks++; if ({sav[0], sav[1], sav[2], sav[3]} !== 32'hFF0000EC)
            $display("FAIL line1_sav: got %h%h%h%h want FF0000EC", sav[0], sav[1], sav[2], sav[3]); else n_pass++;
        n_checks++; if (saw_req !== 0) $display("FAIL line1_no_request: got %0d want 0", saw_req); else n_pass++;
        n_checks++; if (line_f !== 10'd2) $display("FAIL line1_advance: got %0d want 2", line_f); else n_pass++;
        n_checks++; if (errs !== 0)
            $display("FAIL line1_stream: got %0d bad cycles (first at edge %0d) want 0", errs, first_bad); else n_pass++;
    endtask

    task automatic test_field_boundaries();
        int errs = 0, first_bad = -1;
        int t_f_line4 = -1, t_f_field0 = -1, t_s_line266 = -1, t_s_field1 = -1;
        logic [7:0] xy_f4 = 8'h00, xy_s266 = 8'h00, xy_s283 = 8'h00;
        for (int i = 0; i < 20000 && since_rel < 284 * S_LINE; i++) begin
            drive(1'b1, 8'($urandom));
            if (req_f !== ereq_f || col_f !== ecol_f || req_s !== ereq_s || col_s !== ecol_s) errs++;
            step_edge();
            if (dout_f !== edout_f || line_f !== eline_f || field_f !== efield_f ||
                dout_s !== edout_s || line_s !== eline_s || field_s !== efield_s) errs++;
            if (errs != 0 && first_bad < 0) first_bad = since_rel;
            if (t_f_line4 < 0 && line_f === 10'd4) t_f_line4 = since_rel;
            if (t_f_field0 < 0 && field_f === 1'b0) t_f_field0 = since_rel;
            if (t_s_line266 < 0 && line_s === 10'd266) t_s_line266 = since_rel;
            if (t_s_field1 < 0 && field_s === 1'b1) t_s_field1 = since_rel;
            if (pos_ln_f == 4 && pos_h_f == 3) xy_f4 = dout_f;
            if (pos_ln_s == 266 && pos_h_s == 3) xy_s266 = dout_s;
            if (pos_ln_s == 283 && pos_h_s == 3) xy_s283 = dout_s;
        end
        n_checks++; if (t_f_line4 !== 3 * F_LINE) $display("FAIL line4_edge: got %0d want %0d", t_f_line4, 3 * F_LINE); else n_pass++;
        n_checks++; if (t_f_field0 !== 3 * F_LINE) $display("FAIL field_3_to_4: got %0d want %0d", t_f_field0, 3 * F_LINE); else n_pass++;
        n_checks++; if (t_s_line266 !== 265 * S_LINE) $display("FAIL line266_edge: got %0d want %0d", t_s_line266, 265 * S_LINE); else n_pass++;
        n_checks++; if (t_s_field1 !== 265 * S_LINE) $display("FAIL field_265_to_266: got %0d want %0d", t_s_field1, 265 * S_LINE); else n_pass++;
        n_checks++; if (xy_f4 !== 8'hB6) $display("FAIL line4_eav_xy: got %h want B6", xy_f4); else n_pass++;
        n_checks++; if (xy_s266 !== 8'hF1) $display("FAIL line266_eav_xy: got %h want F1", xy_s266); else n_pass++;
        n_checks++; if (xy_s283 !== 8'hDA) $display("FAIL line283_eav_xy: got %h want DA", xy_s283); else n_pass++;
        n_checks++; if (errs !== 0)
            $display("FAIL boundary_stream: got %0d bad cycles (first at edge %0d) want 0", errs, first_bad); else n_pass++;
    endtask

    task automatic test_frame_wrap();
        int errs = 0, first_bad = -1;
        logic [9:0] l_before = '0, l_after = '0;
        logic f_before = 1'b0, f_after = 1'b0;
        logic [7:0] d_after = 8'h00;
        for (int i = 0; i < 20000 && since_rel < S_FRAME + 1; i++) begin
            drive(1'b1, 8'($urandom));
            if (req_f !== ereq_f || col_f !== ecol_f || req_s !== ereq_s || col_s !== ecol_s) errs++;
            step_edge();
            if (dout_f !== edout_f || line_f !== eline_f || field_f !== efield_f ||
                dout_s !== edout_s || line_s !== eline_s || field_s !== efield_s) errs++;
            if (errs != 0 && first_bad < 0) first_bad = since_rel;
            if (since_rel == S_FRAME - 1) begin l_before = line_s; f_before = field_s; end
            if (since_rel == S_FRAME) begin l_after = line_s; f_after = field_s; end
            if (since_rel == S_FRAME + 1) d_after = dout_s;
        end
        n_checks++; if (l_before !== 10'd525) $display("FAIL wrap_last_line: got %0d want 525", l_before); else n_pass++;
        n_checks++; if (l_after !== 10'd1) $display("FAIL wrap_line: got %0d want 1", l_after); else n_pass++;
        n_checks++; if ({f_before, f_after} !== 2'b11) $display("FAIL wrap_field: got %b%b want 11", f_before, f_after); else n_pass++;
        n_checks++; if (d_after !== 8'hFF) $display("FAIL wrap_first_byte: got %h want FF", d_after); else n_pass++;
        n_checks++; if (errs !== 0)
            $display("FAIL frame_stream: got %0d bad cycles (first at edge %0d) want 0", errs, first_bad); else n_pass++;
    endtask

    task automatic test_active_line();
        int errs = 0, first_bad = -1, reached = 0;
        logic prev_req = 1'b1, req0 = 1'b0, req_last = 1'b0, req_end = 1'b1;
        logic [10:0] col0 = '1, col_last = '0;
        logic [7:0] first_out = 8'h00;
        logic [7:0] eav[4];
        for (int i = 0; i < 40000 && !reached; i++) begin
            if (h_f == FH + 8 && ln_f == 20) begin
                reached = 1;
            end else begin
                drive(1'b1, 8'($urandom));
                prev_req = req_f;
                if (req_f !== ereq_f || col_f !== ecol_f || req_s !== ereq_s || col_s !== ecol_s) errs++;
                step_edge();
                if (dout_f !== edout_f || line_f !== eline_f || field_f !== efield_f ||
                    dout_s !== edout_s || line_s !== eline_s || field_s !== efield_s) errs++;
                if (errs != 0 && first_bad < 0) first_bad = since_rel;
            end
        end
        n_checks++; if (reached !== 1) $display("FAIL line20_reach: got %0d want 1", reached); else n_pass++;
        for (int i = 0; i < FA + 4; i++) begin
            drive(1'b1, 8'h5A);
            if (i == 0) begin req0 = req_f; col0 = col_f; end
            if (i == FA - 1) begin req_last = req_f; col_last = col_f; end
            if (i == FA) req_end = req_f;
            if (req_f !== ereq_f || col_f !== ecol_f) errs++;
            step_edge();
            if (dout_f !== edout_f || line_f !== eline_f || field_f !== efield_f) errs++;
            if (errs != 0 && first_bad < 0) first_bad = since_rel;
            if (i == 0) first_out = dout_f;
            if (i >= FA) eav[i - FA] = dout_f;
        end
        n_checks++; if ({prev_req, req0} !== 2'b01) $display("FAIL request_rise: got %b%b want 01", prev_req, req0); else n_pass++;
        n_checks++; if (col0 !== 11'd0) $display("FAIL first_col: got %0d want 0", col0); else n_pass++;
        n_checks++; if (first_out !== 8'h5A) $display("FAIL active_latency: got %h want 5A", first_out); else n_pass++;
        n_checks++; if ({req_last, col_last} !== {1'b1, 11'd1439})
            $display("FAIL last_col: got %b/%0d want 1/1439", req_last, col_last); else n_pass++;
        n_checks++; if (req_end !== 1'b0) $display("FAIL request_fall: got %b want 0", req_end); else n_pass++;
        n_checks++; if ({eav[0], eav[1], eav[2], eav[3]} !== 32'hFF00009D)
            $display("FAIL line21_eav: got %h%h%h%h want FF00009D", eav[0], eav[1], eav[2], eav[3]); else n_pass++;
        n_checks++; if (errs !== 0)
            $display("FAIL active_stream: got %0d bad cycles (first at edge %0d) want 0", errs, first_bad); else n_pass++;
    endtask

    task automatic test_midline_reset();
        int reached = 0;
        for (int i = 0; i < 4000 && !reached; i++) begin
            if (ln_f == 21 && h_f == 800) reached = 1;
            else begin drive(1'b1, 8'($urandom)); step_edge(); end
        end
        n_checks++; if (reached !== 1) $display("FAIL midline_reach: got %0d want 1", reached); else n_pass++;
        drive(1'b0, 8'($urandom)); step_edge();
        n_checks++; if (dout_f !== 8'h80) $display("FAIL midline_dout: got %h want 80", dout_f); else n_pass++;
        n_checks++; if (line_f !== 10'd1) $display("FAIL midline_line: got %0d want 1", line_f); else n_pass++;
        n_checks++; if (field_f !== 1'b1) $display("FAIL midline_field: got %b want 1", field_f); else n_pass++;
        n_checks++; if (line_s !== 10'd1) $display("FAIL midline_line_small: got %0d want 1", line_s); else n_pass++;
        drive(1'b1, 8'($urandom));
        n_checks++; if (req_f !== 1'b0) $display("FAIL midline_request: got %b want 0", req_f); else n_pass++;
        step_edge();
        n_checks++; if (dout_f !== 8'hFF) $display("FAIL midline_restart: got %h want FF", dout_f); else n_pass++;
        n_checks++; if (dout_s !== 8'hFF) $display("FAIL midline_restart_small: got %h want FF", dout_s); else n_pass++;
    endtask

    task automatic test_guard();
        int reached = 0;
        logic [7:0] g0, g1, g2;
        logic gr;
        logic [7:0] want0, want1;
`ifdef BT656_GUARD_EN
        want0 = 8'h01; want1 = 8'hFE;
`else
        want0 = 8'h00; want1 = 8'hFF;
`endif
        for (int i = 0; i < 4000 && !reached; i++) begin
            if (ln_s == 20 && h_s == SH + 8) reached = 1;
            else begin drive(1'b1, 8'($urandom)); step_edge(); end
        end
        n_checks++; if (reached !== 1) $display("FAIL guard_reach: got %0d want 1", reached); else n_pass++;
        drive(1'b1, 8'h00); gr = req_s; step_edge(); g0 = dout_s;
        drive(1'b1, 8'hFF); step_edge(); g1 = dout_s;
        drive(1'b1, 8'h7F); step_edge(); g2 = dout_s;
        n_checks++; if (gr !== 1'b1) $display("FAIL guard_request: got %b want 1", gr); else n_pass++;
        n_checks++; if (g0 !== want0) $display("FAIL guard_zero: got %h want %h", g0, want0); else n_pass++;
        n_checks++; if (g1 !== want1) $display("FAIL guard_ff: got %h want %h", g1, want1); else n_pass++;
        n_checks++; if (g2 !== 8'h7F) $display("FAIL guard_passthru: got %h want 7F", g2); else n_pass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_line();
        test_field_boundaries();
        test_frame_wrap();
        test_active_line();
        test_midline_reset();
        test_guard();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
